// File: rtl/cpu_types_pkg.sv
// Shared types for the memory-side blocks of the pipelined datapath.
//   word_t      : 32-bit data/address word
//   ramstate_t  : status reported by the single-port RAM
//   arb_state_t : state of the instruction/data memory arbiter
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        IGRANT = 2'd1,
        DGRANT = 2'd2
    } arb_state_t;

endpackage

// File: rtl/starve_counter.sv
// Saturating age counter that bounds how many data grants may be issued in a
// row while a fetch is waiting.
// Ports:
//   CLK      in  clock, rising edge
//   nRST     in  asynchronous reset, active-low
//   inc      in  count one more data grant taken over a pending fetch
//   clr      in  restart the count (fetch granted, or no fetch pending)
//   at_limit out count has reached LIMIT; the next grant must go to fetch
module starve_counter #(
    parameter int LIMIT = 4
) (
    input  logic CLK,
    input  logic nRST,
    input  logic inc,
    input  logic clr,
    output logic at_limit
);

    localparam int W = $clog2(LIMIT + 1);
    localparam logic [W-1:0] MAX_AGE = W'(LIMIT);

    logic [W-1:0] age;

    // NOTE: sequential state is written with non-blocking assignments only,
    // so every flop samples the pre-edge values of its neighbours.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            age <= '0;
        end else if (clr) begin
            age <= '0;
        end else if (inc && (age != MAX_AGE)) begin
            age <= age + 1'b1;
        end
    end

    assign at_limit = (age == MAX_AGE);

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter sharing the single-port RAM between instruction fetch and data
// memory. A transaction is latched when granted and held on the RAM port
// until the RAM reports ACCESS, so the RAM sees a stable request for its whole
// latency. Data has priority; a starve_counter forces a fetch grant after
// STARVE_LIMIT consecutive data grants taken while a fetch was pending.
// Ports:
//   CLK, nRST                   clock / asynchronous active-low reset
//   iREN, iaddr                 fetch request and word address
//   iwait, iload                fetch stall (low only on completion) / read data
//   dREN, dWEN, daddr, dstore   data request (write dominates), address, data
//   dwait, dload                data stall (low only on completion) / read data
//   ramREN, ramWEN              RAM read / write enables
//   ramaddr, ramstore           RAM address / write data
//   ramload, ramstate           RAM read data / RAM status
module mem_arbiter
    import cpu_types_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        iREN,
    input  word_t       iaddr,
    output logic        iwait,
    output word_t       iload,
    input  logic        dREN,
    input  logic        dWEN,
    input  word_t       daddr,
    input  word_t       dstore,
    output logic        dwait,
    output word_t       dload,
    output logic        ramREN,
    output logic        ramWEN,
    output word_t       ramaddr,
    output word_t       ramstore,
    input  word_t       ramload,
    input  logic [1:0]  ramstate
);

    arb_state_t arb_state;
    logic       lat_wr;
    word_t      lat_addr;
    word_t      lat_store;

    logic d_req;
    logic at_limit;
    logic grant_d;
    logic grant_i;
    logic ram_done;
    logic ram_err;
    logic age_inc;
    logic age_clr;

    assign d_req    = dREN | dWEN;
    assign ram_done = (ramstate == ACCESS);
    assign ram_err  = (ramstate == ERROR);

    // Data wins unless a fetch has already been passed over STARVE_LIMIT times.
    assign grant_d = d_req && !(iREN && at_limit);
    assign grant_i = iREN && !grant_d;

    // Age only moves on a grant edge, i.e. while arbitrating in IDLE.
    assign age_inc = (arb_state == IDLE) && grant_d && iREN;
    assign age_clr = (arb_state == IDLE) && (grant_i || (grant_d && !iREN));

    starve_counter #(
        .LIMIT(STARVE_LIMIT)
    ) u_starve (
        .CLK     (CLK),
        .nRST    (nRST),
        .inc     (age_inc),
        .clr     (age_clr),
        .at_limit(at_limit)
    );

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            arb_state <= IDLE;
            lat_wr    <= 1'b0;
            lat_addr  <= '0;
            lat_store <= '0;
        end else begin
            case (arb_state)
                IDLE: begin
                    if (grant_d) begin
                        arb_state <= DGRANT;
                        lat_wr    <= dWEN;
                        lat_addr  <= daddr;
                        lat_store <= dstore;
                    end else if (grant_i) begin
                        arb_state <= IGRANT;
                        lat_wr    <= 1'b0;
                        lat_addr  <= iaddr;
                        lat_store <= '0;
                    end
                end
                // Completion, error (retry via re-arbitration) and abort all
                // return to IDLE; only ACCESS drops the requester's wait.
                IGRANT: if (ram_done || ram_err || !iREN)  arb_state <= IDLE;
                DGRANT: if (ram_done || ram_err || !d_req) arb_state <= IDLE;
                default: arb_state <= IDLE;
            endcase
        end
    end

    // RAM drive is a pure decode of registered state, so a reset drops the
    // enables asynchronously along with arb_state.
    // NOTE: every signal written in always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        iwait    = 1'b1;
        dwait    = 1'b1;
        if (arb_state != IDLE) begin
            ramREN   = !lat_wr;
            ramWEN   = lat_wr;
            ramaddr  = lat_addr;
            ramstore = lat_store;
        end
        if (ram_done) begin
            iwait = (arb_state != IGRANT);
            dwait = (arb_state != DGRANT);
        end
    end

    assign iload = ramload;
    assign dload = ramload;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;
    import cpu_types_pkg::*;

    localparam int LIMIT = 4;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        iREN, dREN, dWEN;
    logic [31:0] iaddr, daddr, dstore;
    logic        iwait, dwait;
    logic [31:0] iload, dload;
    logic        ramREN, ramWEN;
    logic [31:0] ramaddr, ramstore, ramload;
    logic [1:0]  ramstate;

    mem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .CLK(CLK), .nRST(nRST),
        .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dwait(dwait), .dload(dload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr),
        .ramstore(ramstore), .ramload(ramload), .ramstate(ramstate)
    );

    always #5 CLK = ~CLK;

    int n_total = 0;
    int n_bad   = 0;
    int cpl_count = 0;

    typedef struct {
        bit          is_data;
        bit          is_wr;
        logic [31:0] addr;
        logic [31:0] val;
    } exp_t;
    exp_t sb[$];

    // RAM model: BUSY for 'lat' cycles then ACCESS; optional one-shot ERROR.
    logic [31:0] ram_mem [logic [31:0]];
    int lat = 0;
    bit err_pending = 1'b0;
    int busy_cnt = 0;

    function automatic logic [31:0] model_rd(input logic [31:0] a);
        if (ram_mem.exists(a)) return ram_mem[a];
        return {~a[15:0], a[15:0]};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic void push(input bit is_data, input bit is_wr,
                                 input logic [31:0] a, input logic [31:0] v);
        exp_t e;
        e.is_data = is_data;
        e.is_wr   = is_wr;
        e.addr    = a;
        e.val     = v;
        sb.push_back(e);
    endfunction

    initial begin
        ramstate = 2'(FREE);
        ramload  = '0;
        forever begin
            @(posedge CLK); #1;
            if (!(ramREN || ramWEN)) begin
                busy_cnt = 0;
                ramstate = 2'(FREE);
                ramload  = '0;
            end else begin
                if (err_pending && busy_cnt == 0) begin
                    ramstate    = 2'(ERROR);
                    err_pending = 1'b0;
                end else if (busy_cnt >= lat) begin
                    ramstate = 2'(ACCESS);
                    if (ramWEN) ram_mem[ramaddr] = ramstore;
                    else        ramload = model_rd(ramaddr);
                end else begin
                    ramstate = 2'(BUSY);
                end
                busy_cnt++;
            end
        end
    end

    // Completion monitor: pops the scoreboard whenever a wait drops.
    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge CLK);
            if (nRST && (!iwait || !dwait)) begin
                check("wait_excl", 32'(iwait | dwait), 32'd1);
                if (sb.size() == 0) begin
                    check("unexp_cpl", 32'({iwait, dwait}), 32'd3);
                end else begin
                    e = sb.pop_front();
                    check("cpl_side", 32'(!dwait), 32'(e.is_data));
                    check("cpl_addr", ramaddr, e.addr);
                    check("cpl_wen",  32'(ramWEN), 32'(e.is_wr));
                    check("cpl_ren",  32'(ramREN), 32'(!e.is_wr));
                    if (e.is_wr) check("cpl_store", ramstore, e.val);
                    else         check("cpl_load", e.is_data ? dload : iload, e.val);
                end
                cpl_count++;
            end
        end
    endtask

    // Returns at negedge+1 of the cycle that brings cpl_count to target.
    task automatic wait_cpl(input int target, input int budget);
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < budget && !hit; i++) begin
            @(negedge CLK); #1;
            if (cpl_count >= target) hit = 1'b1;
        end
        if (!hit) check("timeout_cpl", 32'(cpl_count), 32'(target));
    endtask

    task automatic check_idle_port(input string tag);
        check({tag, "_ren"},   32'(ramREN), 32'd0);
        check({tag, "_wen"},   32'(ramWEN), 32'd0);
        check({tag, "_addr"},  ramaddr, 32'd0);
        check({tag, "_store"}, ramstore, 32'd0);
        check({tag, "_iwait"}, 32'(iwait), 32'd1);
        check({tag, "_dwait"}, 32'(dwait), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        nRST = 1'b0; iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0;
        iaddr = '0; daddr = '0; dstore = '0;
        ram_mem[32'h40] = 32'hDEAD_BEEF;
        fork monitor(); join_none

        // Reset values
        repeat (2) @(negedge CLK);
        check_idle_port("rst");
        #1 nRST = 1'b1;
        @(negedge CLK);
        check_idle_port("post_rst");

        // Single fetch, two BUSY cycles then ACCESS
        @(posedge CLK); #2;
        lat = 2; iREN = 1'b1; iaddr = 32'h40;
        push(1'b0, 1'b0, 32'h40, 32'hDEAD_BEEF);
        for (int c = 0; c <= 4; c++) begin
            @(negedge CLK);
            check($sformatf("sf_ren_c%0d", c), 32'(ramREN), 32'((c >= 1) && (c <= 3)));
            check($sformatf("sf_iwait_c%0d", c), 32'(iwait), 32'(c != 3));
            check($sformatf("sf_dwait_c%0d", c), 32'(dwait), 32'd1);
            if (c == 3) begin #1 iREN = 1'b0; end
        end

        // Simultaneous fetch and data write, ACCESS immediate
        @(posedge CLK); #2;
        lat = 0;
        iREN = 1'b1; iaddr = 32'h100;
        dWEN = 1'b1; daddr = 32'h80; dstore = 32'h1234;
        push(1'b1, 1'b1, 32'h80, 32'h1234);
        push(1'b0, 1'b0, 32'h100, model_rd(32'h100));
        @(negedge CLK);
        @(negedge CLK);  // cycle 1
        check("sim_wen",   32'(ramWEN), 32'd1);
        check("sim_addr",  ramaddr, 32'h80);
        check("sim_store", ramstore, 32'h1234);
        check("sim_dwait", 32'(dwait), 32'd0);
        check("sim_iwait", 32'(iwait), 32'd1);
        #1 dWEN = 1'b0;
        @(negedge CLK);  // cycle 2: mandatory bubble
        check("sim_bub_ren", 32'(ramREN | ramWEN), 32'd0);
        @(negedge CLK);  // cycle 3: fetch granted
        check("sim_f_ren",   32'(ramREN), 32'd1);
        check("sim_f_addr",  ramaddr, 32'h100);
        check("sim_f_iwait", 32'(iwait), 32'd0);
        #1 iREN = 1'b0;
        @(negedge CLK);

        // Starvation: both held, expect LIMIT data then one fetch, twice
        @(posedge CLK); #2;
        base = cpl_count;
        iREN = 1'b1; iaddr = 32'h300; dREN = 1'b1; daddr = 32'h200;
        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < LIMIT; k++) push(1'b1, 1'b0, 32'h200, model_rd(32'h200));
            push(1'b0, 1'b0, 32'h300, model_rd(32'h300));
        end
        wait_cpl(base + 2 * (LIMIT + 1), 100);
        iREN = 1'b0; dREN = 1'b0;
        repeat (2) @(negedge CLK);
        check("starve_sb_empty", 32'(sb.size()), 32'd0);

        // ERROR retry on a fetch
        @(posedge CLK); #2;
        lat = 0; err_pending = 1'b1; iREN = 1'b1; iaddr = 32'h44;
        push(1'b0, 1'b0, 32'h44, model_rd(32'h44));
        @(negedge CLK);
        @(negedge CLK);  // cycle 1: ERROR
        check("err_ren",   32'(ramREN), 32'd1);
        check("err_iwait", 32'(iwait), 32'd1);
        @(negedge CLK);  // cycle 2: back in IDLE
        check("err_idle_ren", 32'(ramREN), 32'd0);
        check("err_idle_iwait", 32'(iwait), 32'd1);
        @(negedge CLK);  // cycle 3: retried and completed
        check("err_retry_ren", 32'(ramREN), 32'd1);
        check("err_retry_iwait", 32'(iwait), 32'd0);
        #1 iREN = 1'b0;
        @(negedge CLK);

        // Abort: data read dropped while BUSY
        @(posedge CLK); #2;
        lat = 20; dREN = 1'b1; daddr = 32'h500;
        @(negedge CLK);
        @(negedge CLK);  // cycle 1
        check("abt_ren_c1", 32'(ramREN), 32'd1);
        check("abt_dwait_c1", 32'(dwait), 32'd1);
        @(posedge CLK); #2 dREN = 1'b0;  // cycle 2
        @(negedge CLK);
        check("abt_dwait_c2", 32'(dwait), 32'd1);
        @(negedge CLK);  // cycle 3
        check("abt_ren_c3", 32'(ramREN), 32'd0);
        check("abt_dwait_c3", 32'(dwait), 32'd1);

        // Reset mid-transaction with age non-zero, then age must restart at 0
        @(posedge CLK); #2;
        lat = 0; base = cpl_count;
        iREN = 1'b1; iaddr = 32'h704; dREN = 1'b1; daddr = 32'h700;
        push(1'b1, 1'b0, 32'h700, model_rd(32'h700));
        push(1'b1, 1'b0, 32'h700, model_rd(32'h700));
        wait_cpl(base + 2, 40);
        lat = 20;
        @(negedge CLK);  // IDLE bubble
        @(negedge CLK);  // third data grant, BUSY
        check("rmid_ren", 32'(ramREN), 32'd1);
        check("rmid_addr", ramaddr, 32'h700);
        #1 nRST = 1'b0;
        #1;
        check_idle_port("rmid");
        @(negedge CLK);
        lat = 0; base = cpl_count;
        for (int k = 0; k < LIMIT; k++) push(1'b1, 1'b0, 32'h700, model_rd(32'h700));
        push(1'b0, 1'b0, 32'h704, model_rd(32'h704));
        #1 nRST = 1'b1;
        wait_cpl(base + LIMIT + 1, 60);
        iREN = 1'b0; dREN = 1'b0;
        repeat (3) @(negedge CLK);
        check("final_sb_empty", 32'(sb.size()), 32'd0);
        check_idle_port("final");

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Sequential arbiter sharing the single-port RAM between the instruction-fetch side and the data-memory side of the pipelined datapath. Each transaction is latched at grant and held on the RAM port until the RAM reports completion, so the RAM sees a stable request for its full latency. Data requests have priority, and a bounded age counter guarantees that fetch cannot starve. Sits between the cache-facing request ports and the RAM.

## Interface
Parameters:
- STARVE_LIMIT, 4, maximum consecutive data grants while a fetch is pending; must be ≥ 1.

Ports:
- CLK  in  1  clock, rising edge.
- nRST  in  1  asynchronous reset, active-low.
- iREN  in  1  fetch read request.
- iaddr  in  32  fetch word address.
- iwait  out  1  fetch stall; low for exactly the completing cycle.
- iload  out  32  fetch read data.
- dREN  in  1  data read request.
- dWEN  in  1  data write request; dominates dREN.
- daddr  in  32  data address.
- dstore  in  32  data write value.
- dwait  out  1  data stall; low for exactly the completing cycle.
- dload  out  32  data read data.
- ramREN  out  1  RAM read enable.
- ramWEN  out  1  RAM write enable.
- ramaddr  out  32  RAM address.
- ramstore  out  32  RAM write data.
- ramload  in  32  RAM read data.
- ramstate  in  2  RAM status: FREE=0, BUSY=1, ACCESS=2, ERROR=3.

## Operation
- State register arb_state: IDLE, IGRANT, DGRANT. Reset state is IDLE.
- Arbitration happens only in IDLE, from the current inputs:
  - Grant DGRANT if (dREN|dWEN), unless iREN is high and age == STARVE_LIMIT; in that case grant IGRANT.
  - Otherwise grant IGRANT if iREN.
  - Otherwise stay in IDLE.
- On the grant edge, latch the transaction into registers:
  - op (write = dWEN, else read);
  - address (daddr or iaddr);
  - store value (dstore; 0 for fetch).
- In IGRANT or DGRANT, drive the latched transaction:
  - ramaddr and ramstore from the latches;
  - ramREN = read op;
  - ramWEN = write op (fetch is always read).
- In IDLE, ramREN=ramWEN=0 and ramaddr=ramstore=0.
- Completion: in a grant state with ramstate==ACCESS, the granted side's wait goes low that cycle; next state is IDLE.
- ERROR in a grant state: no completion, wait stays high, next state is IDLE; the request re-arbitrates (retry).
- FREE or BUSY in a grant state: hold the state.
- Abort: if the granted requester deasserts its request(s) in a grant state, go to IDLE next cycle with no completion.
  - ramstate==ACCESS in that same cycle takes precedence: it completes normally.
- Requesters must hold request, address and data stable until their wait goes low. Changes are ignored while granted, because the latches drive the RAM.
- iload = dload = ramload, combinational passthrough, always driven.
- Age counter:
  - On a DGRANT grant with iREN high, increment, saturating at STARVE_LIMIT.
  - On any IGRANT grant, clear to 0.
  - On a DGRANT grant with iREN low, clear to 0.
  - Otherwise hold.
  - Width is $clog2(STARVE_LIMIT+1).

## Timing
- Reset values: arb_state=IDLE, age=0, latches=0, iwait=dwait=1, ramREN=ramWEN=0, ramaddr=ramstore=0.
- Arbitration latency: request seen in IDLE at cycle 0; RAM enables asserted from cycle 1.
- Minimum transaction: with ACCESS in cycle 1, wait is low in cycle 1 and the state is back to IDLE in cycle 2.
- One mandatory IDLE bubble between transactions; back-to-back throughput is at most one transaction per 2 cycles.
- iwait and dwait are never low simultaneously. The non-granted side's wait is always 1.
- Simultaneous iREN and dREN in IDLE with age < STARVE_LIMIT: data wins.
- Reset mid-transaction: immediate return to reset values, RAM enables drop asynchronously, and the transaction is lost.

## Structure
- cpu_types_pkg holds:
  - ramstate_t (FREE, BUSY, ACCESS, ERROR), 2-bit enum;
  - word_t (32-bit);
  - arb_state_t (IDLE, IGRANT, DGRANT).
- One sub-module, starve_counter: parameter LIMIT; inputs CLK, nRST, inc, clr; output at_limit. It encapsulates the saturating age logic.

## Test plan
- Single fetch: iREN=1, iaddr=0x40, RAM answers ACCESS after 2 BUSY cycles with ramload=0xDEADBEEF. Required: ramREN=1 on cycles 1–3, iwait=0 only on cycle 3, iload=0xDEADBEEF.
- Simultaneous requests: iREN=1 and dWEN=1 (daddr=0x80, dstore=0x1234), ACCESS in 1 cycle. Required: data granted first (ramWEN=1, ramaddr=0x80, ramstore=0x1234), dwait low in cycle 1; fetch then granted from cycle 3.
- Starvation: dREN and iREN held high, ACCESS immediate, STARVE_LIMIT=4. Required: exactly 4 data completions, then one fetch completion, then the pattern repeats.
- ERROR retry: fetch granted, ramstate=ERROR in cycle 1, then ACCESS. Required: iwait stays 1 through the error, the state returns to IDLE, the fetch is re-granted and completes; age is unchanged.
- Abort: data read granted with ramstate=BUSY, dREN dropped in cycle 2. Required: IDLE in cycle 3, ramREN=0, dwait never low.
- Reset mid-transaction: nRST low during DGRANT with BUSY. Required: ramWEN/ramREN=0 immediately, iwait=dwait=1, age=0 after release.
